// File: rtl/i2c_sensor_target.sv
// I2C target with a small register file, pointer-based auto-increment access and one live sensor register.
// Build option: define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample majority filter on SCL/SDA.
module i2c_sensor_target #(
    parameter int         DATA_DEPTH  = 8,
    parameter logic [6:0] TARGET_ADDR = 7'h4E,
    parameter int         NUM_REGS    = 16,
    parameter int         SENSOR_REG  = 0,
    localparam int        ADDR_W      = $clog2(NUM_REGS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_scl,
    input  logic                  i_sda,
    output logic                  o_sda_oe,
    input  logic [DATA_DEPTH-1:0] i_sensor_bits,
    output logic                  o_sensor_read,
    output logic                  o_wr_valid,
    output logic [ADDR_W-1:0]     o_wr_addr,
    output logic [DATA_DEPTH-1:0] o_wr_bits,
    output logic                  o_busy
);

    localparam logic [ADDR_W-1:0] SENSOR_IDX = ADDR_W'(SENSOR_REG);
    localparam logic [3:0]        LAST_BIT   = 4'(DATA_DEPTH - 1);
    localparam logic [3:0]        BYTE_DONE  = 4'(DATA_DEPTH);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
    } state_t;

    state_t                  state, state_nxt;
    logic [3:0]              bit_cnt, bit_cnt_nxt;
    logic [DATA_DEPTH-1:0]   shift, shift_nxt;
    logic [ADDR_W-1:0]       pointer, pointer_nxt;
    logic                    oe_nxt, busy_nxt, wr_valid_nxt, sensor_read_nxt, reg_we;
    logic [ADDR_W-1:0]       wr_addr_nxt;
    logic [DATA_DEPTH-1:0]   wr_bits_nxt;
    logic [DATA_DEPTH-1:0]   regs [NUM_REGS];

    logic scl_p0, scl_p1, scl_p2, sda_p0, sda_p1, sda_p2;
    logic scl, sda;

    // Stage p0/p1: two-flop synchronizers; idle bus level is high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_p0 <= 1'b1;
            scl_p1 <= 1'b1;
            sda_p0 <= 1'b1;
            sda_p1 <= 1'b1;
        end else begin
            scl_p0 <= i_scl;
            scl_p1 <= scl_p0;
            sda_p0 <= i_sda;
            sda_p1 <= sda_p0;
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    function automatic logic majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [1:0] scl_hist, sda_hist;
    logic       scl_flt, sda_flt;

    // Filter stage: registered majority of the last three synchronized samples.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_flt  <= 1'b1;
            sda_flt  <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_p1};
            sda_hist <= {sda_hist[0], sda_p1};
            scl_flt  <= majority(scl_p1, scl_hist[0], scl_hist[1]);
            sda_flt  <= majority(sda_p1, sda_hist[0], sda_hist[1]);
        end
    end

    assign scl = scl_flt;
    assign sda = sda_flt;
`else
    assign scl = scl_p1;
    assign sda = sda_p1;
`endif

    // Stage p2: previous sample for edge and bus-condition detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scl_p2 <= 1'b1;
            sda_p2 <= 1'b1;
        end else begin
            scl_p2 <= scl;
            sda_p2 <= sda;
        end
    end

    logic                  scl_rise, scl_fall, start_cond, stop_cond;
    logic [DATA_DEPTH-1:0] rx_byte, load_byte;
    logic [ADDR_W-1:0]     load_idx;

    assign scl_rise   = scl & ~scl_p2;
    assign scl_fall   = ~scl & scl_p2;
    assign start_cond = scl & scl_p2 & sda_p2 & ~sda;
    assign stop_cond  = scl & scl_p2 & ~sda_p2 & sda;
    assign rx_byte    = {shift[DATA_DEPTH-2:0], sda};

    // A byte loaded from RACK belongs to the next pointer value.
    assign load_idx  = (state == RACK) ? pointer + ADDR_W'(1) : pointer;
    assign load_byte = (load_idx == SENSOR_IDX) ? i_sensor_bits : regs[load_idx];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift         <= '0;
            pointer       <= '0;
            o_sda_oe      <= 1'b0;
            o_busy        <= 1'b0;
            o_wr_valid    <= 1'b0;
            o_wr_addr     <= '0;
            o_wr_bits     <= '0;
            o_sensor_read <= 1'b0;
        end else begin
            state         <= state_nxt;
            bit_cnt       <= bit_cnt_nxt;
            shift         <= shift_nxt;
            pointer       <= pointer_nxt;
            o_sda_oe      <= oe_nxt;
            o_busy        <= busy_nxt;
            o_wr_valid    <= wr_valid_nxt;
            o_wr_addr     <= wr_addr_nxt;
            o_wr_bits     <= wr_bits_nxt;
            o_sensor_read <= sensor_read_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (reg_we) begin
            regs[pointer] <= rx_byte;
        end
    end

    always_comb begin
        state_nxt       = state;
        bit_cnt_nxt     = bit_cnt;
        shift_nxt       = shift;
        pointer_nxt     = pointer;
        oe_nxt          = o_sda_oe;
        busy_nxt        = o_busy;
        wr_valid_nxt    = 1'b0;
        wr_addr_nxt     = o_wr_addr;
        wr_bits_nxt     = o_wr_bits;
        sensor_read_nxt = 1'b0;
        reg_we          = 1'b0;

        if (start_cond) begin
            state_nxt   = ADDR;
            bit_cnt_nxt = '0;
            oe_nxt      = 1'b0;
            busy_nxt    = 1'b0;
        end else if (stop_cond) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
            oe_nxt      = 1'b0;
            busy_nxt    = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        shift_nxt   = rx_byte;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == LAST_BIT) begin
                            if (rx_byte[DATA_DEPTH-1 -: 7] == TARGET_ADDR) begin
                                state_nxt = ADDR_ACK;
                                busy_nxt  = 1'b1;
                            end else begin
                                state_nxt = IGNORE;
                            end
                        end
                    end
                end
                // In the ACK states the first falling edge starts the ACK and the
                // second ends it, so the current drive level tells the two apart.
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!o_sda_oe) begin
                            oe_nxt = 1'b1;
                        end else if (shift[0]) begin
                            shift_nxt       = load_byte;
                            oe_nxt          = ~load_byte[DATA_DEPTH-1];
                            bit_cnt_nxt     = '0;
                            sensor_read_nxt = (pointer == SENSOR_IDX);
                            state_nxt       = RDATA;
                        end else begin
                            oe_nxt      = 1'b0;
                            bit_cnt_nxt = '0;
                            state_nxt   = PTR;
                        end
                    end
                end
                PTR: begin
                    if (scl_rise) begin
                        shift_nxt   = rx_byte;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == LAST_BIT) begin
                            pointer_nxt = rx_byte[ADDR_W-1:0];
                            state_nxt   = PTR_ACK;
                        end
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!o_sda_oe) begin
                            oe_nxt = 1'b1;
                        end else begin
                            oe_nxt      = 1'b0;
                            bit_cnt_nxt = '0;
                            state_nxt   = WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (scl_rise) begin
                        shift_nxt   = rx_byte;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == LAST_BIT) begin
                            state_nxt   = WDATA_ACK;
                            pointer_nxt = pointer + ADDR_W'(1);
                            if (pointer != SENSOR_IDX) begin
                                reg_we       = 1'b1;
                                wr_valid_nxt = 1'b1;
                                wr_addr_nxt  = pointer;
                                wr_bits_nxt  = rx_byte;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == BYTE_DONE) begin
                            oe_nxt    = 1'b0;
                            state_nxt = RACK;
                        end else if (bit_cnt == 4'd0) begin
                            oe_nxt = ~shift[DATA_DEPTH-1];
                        end else begin
                            shift_nxt = {shift[DATA_DEPTH-2:0], 1'b0};
                            oe_nxt    = ~shift[DATA_DEPTH-2];
                        end
                    end
                end
                RACK: begin
                    if (scl_rise) begin
                        if (!sda) begin
                            pointer_nxt     = load_idx;
                            shift_nxt       = load_byte;
                            sensor_read_nxt = (load_idx == SENSOR_IDX);
                            bit_cnt_nxt     = '0;
                            state_nxt       = RDATA;
                        end else begin
                            state_nxt = IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
